// File: rtl/baccarat_round_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// baccarat_pkg
// Shared types and defaults for the baccarat round scheduler.
//   round_state_t : scheduler FSM states (ABORT only with BACCARAT_ROUND_WATCHDOG_EN)
//   result_t      : round outcome encoding, bit0 = player lit, bit1 = dealer lit
//   DEF_*         : default timing constants
// -----------------------------------------------------------------------------
package baccarat_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_PLAY,
`ifdef BACCARAT_ROUND_WATCHDOG_EN
        ST_HOLD,
        ST_ABORT
`else
        ST_HOLD
`endif
    } round_state_t;

    typedef enum logic [1:0] {
        RES_NONE   = 2'b00,
        RES_PLAYER = 2'b01,
        RES_DEALER = 2'b10,
        RES_TIE    = 2'b11
    } result_t;

    localparam int DEF_HOLD_CYCLES = 4;
    localparam int DEF_RST_CYCLES  = 2;
    localparam int DEF_TIMEOUT     = 16;

    // The encoding is chosen so that the two lights map straight onto it:
    // both lit gives TIE without any extra priority logic.
    function automatic result_t classify(input logic player_lit, input logic dealer_lit);
        return result_t'({dealer_lit, player_lit});
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/baccarat_round_scheduler_if.sv
// -----------------------------------------------------------------------------
// baccarat_round_scheduler_if
// Control/status bundle between the top-level controls, the card-dealing
// statemachine and the round scheduler.
//   start, stop                        : session controls (from keys/switches)
//   player_win_light, dealer_win_light : from the statemachine
//   sm_resetb                          : drives the statemachine reset
//   busy, result_valid, last_result    : scheduler status
//   player_wins, dealer_wins, ties,
//   rounds_played                      : CNT_W-bit tallies
//   err                                : watchdog flag
// Modports: master = environment side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface baccarat_round_scheduler_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             stop;
    logic             player_win_light;
    logic             dealer_win_light;
    logic             sm_resetb;
    logic             busy;
    logic             result_valid;
    logic [1:0]       last_result;
    logic [CNT_W-1:0] player_wins;
    logic [CNT_W-1:0] dealer_wins;
    logic [CNT_W-1:0] ties;
    logic [CNT_W-1:0] rounds_played;
    logic             err;

    modport master (
        output start, stop, player_win_light, dealer_win_light,
        input  sm_resetb, busy, result_valid, last_result,
               player_wins, dealer_wins, ties, rounds_played, err
    );

    modport slave (
        input  start, stop, player_win_light, dealer_win_light,
        output sm_resetb, busy, result_valid, last_result,
               player_wins, dealer_wins, ties, rounds_played, err
    );
endinterface

// File: rtl/baccarat_round_scheduler_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count up by one unless already saturated
//   count      : current value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end
endmodule

// File: rtl/baccarat_round_scheduler.sv
// -----------------------------------------------------------------------------
// baccarat_round_scheduler
// Runs back-to-back baccarat rounds on the card-dealing statemachine: pulses
// its reset, waits for a win light, tallies the outcome, holds the result for
// display, then repeats until NUM_ROUNDS rounds are done or stop is seen.
//   slow_clock : clock
//   resetb     : asynchronous active-low reset
//   bus        : baccarat_round_scheduler_if.slave (controls, lights, status)
// Optional build macro BACCARAT_ROUND_WATCHDOG_EN adds a PLAY watchdog that
// aborts a round after TIMEOUT cycles without a light and raises err.
// -----------------------------------------------------------------------------
module baccarat_round_scheduler
    import baccarat_pkg::*;
#(
    parameter int NUM_ROUNDS  = 8,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int RST_CYCLES  = DEF_RST_CYCLES,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input logic                       slow_clock,
    input logic                       resetb,
    baccarat_round_scheduler_if.slave bus
);
    // One timer is shared by RST, HOLD and (optionally) PLAY.
    localparam int TMR_W = $clog2(max3(HOLD_CYCLES, RST_CYCLES, TIMEOUT) + 1);
    localparam logic [TMR_W-1:0] RST_LAST  = TMR_W'(RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
`ifdef BACCARAT_ROUND_WATCHDOG_EN
    localparam logic [TMR_W-1:0] PLAY_LAST = TMR_W'(TIMEOUT - 1);
`endif

    round_state_t     state_q, state_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    result_t          result_q, result_d, outcome;
    logic             stop_seen_q, stop_seen_d;
    logic             sm_resetb_q, busy_q, result_valid_q;
    logic             clr_tally, inc_player, inc_dealer, inc_tie, inc_round;
    logic             any_light, rounds_done;
    logic [CNT_W-1:0] player_wins, dealer_wins, ties, rounds_played;
`ifdef BACCARAT_ROUND_WATCHDOG_EN
    logic             err_q, err_d;
`endif

    assign any_light   = bus.player_win_light | bus.dealer_win_light;
    assign rounds_done = (NUM_ROUNDS != 0) && (int'(rounds_played) == NUM_ROUNDS);

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        result_d    = result_q;
        clr_tally   = 1'b0;
        inc_player  = 1'b0;
        inc_dealer  = 1'b0;
        inc_tie     = 1'b0;
        inc_round   = 1'b0;
        outcome     = classify(bus.player_win_light, bus.dealer_win_light);
        // stop is remembered from any busy cycle, including the expiry edge.
        stop_seen_d = stop_seen_q | ((state_q != ST_IDLE) & bus.stop);
`ifdef BACCARAT_ROUND_WATCHDOG_EN
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                stop_seen_d = 1'b0;
                if (bus.start) begin
                    state_d   = ST_RST;
                    tmr_d     = '0;
                    clr_tally = 1'b1;
                    result_d  = RES_NONE;
`ifdef BACCARAT_ROUND_WATCHDOG_EN
                    err_d     = 1'b0;
`endif
                end
            end
            ST_RST: begin
                if (tmr_q == RST_LAST) begin
                    state_d = ST_PLAY;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            ST_PLAY: begin
                if (any_light) begin
                    state_d    = ST_HOLD;
                    tmr_d      = '0;
                    result_d   = outcome;
                    inc_player = (outcome == RES_PLAYER);
                    inc_dealer = (outcome == RES_DEALER);
                    inc_tie    = (outcome == RES_TIE);
                    inc_round  = 1'b1;
`ifdef BACCARAT_ROUND_WATCHDOG_EN
                end else if (tmr_q == PLAY_LAST) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    tmr_d = tmr_q + 1'b1;
`endif
                end
            end
            ST_HOLD: begin
                if (tmr_q == HOLD_LAST) begin
                    if (stop_seen_d || rounds_done) begin
                        state_d     = ST_IDLE;
                        stop_seen_d = 1'b0;
                    end else begin
                        state_d = ST_RST;
                        tmr_d   = '0;
                    end
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
`ifdef BACCARAT_ROUND_WATCHDOG_EN
            ST_ABORT: begin
                state_d     = ST_IDLE;
                stop_seen_d = 1'b0;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state they describe and never see the inputs combinationally.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q        <= ST_IDLE;
            tmr_q          <= '0;
            result_q       <= RES_NONE;
            stop_seen_q    <= 1'b0;
            sm_resetb_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            result_q       <= result_d;
            stop_seen_q    <= stop_seen_d;
            sm_resetb_q    <= (state_d == ST_PLAY) || (state_d == ST_HOLD);
            busy_q         <= (state_d != ST_IDLE);
            result_valid_q <= (state_d == ST_HOLD);
        end
    end

`ifdef BACCARAT_ROUND_WATCHDOG_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    sat_counter #(.CNT_W(CNT_W)) u_player_cnt (
        .clk(slow_clock), .rst_n(resetb), .clr(clr_tally), .inc(inc_player), .count(player_wins)
    );
    sat_counter #(.CNT_W(CNT_W)) u_dealer_cnt (
        .clk(slow_clock), .rst_n(resetb), .clr(clr_tally), .inc(inc_dealer), .count(dealer_wins)
    );
    sat_counter #(.CNT_W(CNT_W)) u_tie_cnt (
        .clk(slow_clock), .rst_n(resetb), .clr(clr_tally), .inc(inc_tie), .count(ties)
    );
    sat_counter #(.CNT_W(CNT_W)) u_round_cnt (
        .clk(slow_clock), .rst_n(resetb), .clr(clr_tally), .inc(inc_round), .count(rounds_played)
    );

    assign bus.sm_resetb     = sm_resetb_q;
    assign bus.busy          = busy_q;
    assign bus.result_valid  = result_valid_q;
    assign bus.last_result   = result_q;
    assign bus.player_wins   = player_wins;
    assign bus.dealer_wins   = dealer_wins;
    assign bus.ties          = ties;
    assign bus.rounds_played = rounds_played;
endmodule

// File: doc/baccarat_round_scheduler.md
# baccarat_round_scheduler

Sequences back-to-back baccarat rounds on the existing card-dealing `statemachine`. It owns that statemachine's `resetb`, detects round completion from the win lights, and keeps running tallies of player wins, dealer wins and ties. It holds each result for a fixed display window, then starts the next round until a programmed round count is reached or `stop` is asserted. It sits between the top-level controls (keys/switches) and the `statemachine`/datapath pair, on the same `slow_clock`.

## Interface
- `NUM_ROUNDS`, default 8: rounds per session; 0 = continuous until `stop`.
- `HOLD_CYCLES`, default 4: cycles a result is held before the next round (≥1).
- `RST_CYCLES`, default 2: cycles `sm_resetb` is held low before each round (≥1).
- `CNT_W`, default 8: width of every tally/round counter.
- `TIMEOUT`, default 16: watchdog limit in PLAY cycles (only with the watchdog macro).

Ports:
- `slow_clock` in 1: the single clock; all state changes on its rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `start` in 1: level-sampled; starts a session from IDLE, ignored otherwise.
- `stop` in 1: level-sampled; ends the session after the current HOLD completes.
- `player_win_light` in 1: from `statemachine`.
- `dealer_win_light` in 1: from `statemachine`.
- `sm_resetb` out 1: drives the statemachine's `resetb`.
- `busy` out 1: high in every state except IDLE.
- `result_valid` out 1: high during HOLD.
- `last_result` out 2: 00 none, 01 player, 10 dealer, 11 tie.
- `player_wins`, `dealer_wins`, `ties`, `rounds_played` out CNT_W: tallies.
- `err` out 1: watchdog flag (tied 0 when compiled out).

## Operation
- States: IDLE, RST, PLAY, HOLD, plus ABORT when the watchdog is compiled in.
- IDLE:
  - `sm_resetb`=0.
  - `start`=1 → RST; clears all tallies, `last_result` and `err` on that edge.
- RST:
  - `sm_resetb`=0 for exactly RST_CYCLES cycles, then → PLAY.
  - Counter reloads on each entry.
- PLAY:
  - `sm_resetb`=1; the statemachine deals.
  - On the first edge where either light is 1 → HOLD.
  - The outcome is classified from the lights sampled on that edge: both = tie, else whichever is lit.
  - On the same edge: increment the matching tally and `rounds_played`, and update `last_result`.
- HOLD:
  - `sm_resetb` stays 1 so the lights remain visible; `result_valid`=1 for HOLD_CYCLES cycles.
  - At expiry: if `stop` was seen (sticky from any cycle after session start), or `NUM_ROUNDS`≠0 and `rounds_played`==NUM_ROUNDS → IDLE.
  - Otherwise → RST.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Continuous mode stops only on `stop`; `rounds_played` keeps counting, saturating, and the session continues.
- `stop` in IDLE is ignored. `start` while busy is ignored.
- `stop` and round-count completion in the same HOLD → IDLE (a single transition).
- Sticky stop clears on entry to IDLE.
- Asynchronous reset mid-session:
  - IDLE immediately, all outputs to reset values.
  - The statemachine is forced into reset the same instant via `sm_resetb`=0.

## Timing
- Reset values: `sm_resetb`=0, `busy`=0, `result_valid`=0, `last_result`=00, all tallies 0, `err`=0.
- `start` sampled high at edge k:
  - `busy`=1 after k.
  - `sm_resetb` rises after edge k+RST_CYCLES.
- Tally and `last_result` update is visible after the light-detection edge, i.e. the same edge PLAY→HOLD.
- `result_valid` is high for exactly HOLD_CYCLES cycles per round.
- Round-to-round turnaround (HOLD exit to `sm_resetb` high) is RST_CYCLES cycles.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- Macro: `BACCARAT_ROUND_WATCHDOG_EN`.
- Defined:
  - A PLAY cycle counter runs from 0 on PLAY entry.
  - When it reaches TIMEOUT without a light → ABORT: `err`=1 (sticky until next `start`), no tally change.
  - ABORT holds `sm_resetb`=0 for one cycle, then → IDLE.
- Undefined: PLAY waits indefinitely; `err` is constant 0; no counter logic synthesised.

## Structure
- Shared package `baccarat_pkg`:
  - State enum `round_state_t`.
  - Result encoding `result_t` (NONE/PLAYER/DEALER/TIE).
  - Default constants for HOLD_CYCLES, RST_CYCLES and TIMEOUT.
- One sub-module, `sat_counter` (parameter CNT_W; inputs inc, clr): instantiated for each of the four tallies.
- The FSM and the hold/reset/watchdog timers stay in the top module.

## Test plan
- Reset then idle: assert `resetb`=0 for 2 cycles, release, hold `start`=0 for 10 cycles → `sm_resetb`=0, `busy`=0, all tallies 0.
- Single player win: NUM_ROUNDS=1, `start` pulse, model raises `player_win_light` 3 cycles after `sm_resetb` rises → `player_wins`=1, `last_result`=01, `result_valid` high 4 cycles, then IDLE with `busy`=0.
- Tie and mixed tallies: NUM_ROUNDS=3, rounds return player, both lights, dealer → `player_wins`=1, `ties`=1, `dealer_wins`=1, `rounds_played`=3, `sm_resetb` low exactly 2 cycles between rounds.
- Stop in continuous mode: NUM_ROUNDS=0, pulse `stop` during round 2 PLAY → round 2 tallied, HOLD completes, IDLE, `rounds_played`=2.
- Saturation: CNT_W=2, NUM_ROUNDS=0, 5 player wins then `stop` → `player_wins`=3 and `rounds_played`=3, no wrap.
- Watchdog (macro defined): TIMEOUT=16, lights never assert → `err`=1 after 16 PLAY cycles, `sm_resetb`=0, IDLE, tallies unchanged; next `start` clears `err`.
